// File: rtl/seven_seg_scan_driver_pkg.sv
// seven_seg_pkg: segment glyphs, nibble decode and controller states
package seven_seg_pkg;
  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  function automatic logic [0:6] nib2seg(input logic [3:0] nib, input logic hex_en);
    return (nib > 4'd9 && !hex_en) ? BLANK : GLYPHS[nib];
  endfunction
endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: host load bus and display pin bundle
interface seven_seg_scan_driver_if #(parameter int NUM_DIGITS = 4) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    bin_mode;
  logic                    hex_en;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    busy;
  logic                    done;
  logic [0:6]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  modport master (output load, value, bin_mode, hex_en, blank_lz, dp_in,
                  input busy, done, seg_out, dp_out, an_out);
  modport slave (input load, value, bin_mode, hex_en, blank_lz, dp_in,
                 output busy, done, seg_out, dp_out, an_out);
endinterface

// File: rtl/seven_seg_scan_driver_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble binary to packed BCD converter
module bin2bcd_seq #(
  parameter int BIN_W = 13,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    valid
);
  localparam int W = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  logic [W+BIN_W-1:0] sh_q;
  logic [CW-1:0]      cnt_q;
  logic               valid_q;
  function automatic logic [W+BIN_W-1:0] step(input logic [W+BIN_W-1:0] s);
    logic [W+BIN_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (t[BIN_W+4*i +: 4] > 4'd4) t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
    return t << 1;
  endfunction
  // first iteration runs on start, so the last of BIN_W lands BIN_W-1 cycles later
  always_ff @(posedge clk)
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      sh_q <= step({{W{1'b0}}, bin});
      cnt_q <= CW'(BIN_W - 1);
      valid_q <= (BIN_W == 1);
    end else if (cnt_q != '0) begin
      sh_q <= step(sh_q);
      cnt_q <= cnt_q - 1'b1;
      valid_q <= (cnt_q == CW'(1));
    end
  assign bcd = sh_q[W+BIN_W-1:BIN_W];
  assign valid = valid_q;
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: buffered, multiplexed seven-segment display driver
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BIN_W = 13
) (
  input logic clk,
  input logic rst,
  seven_seg_scan_driver_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t                state_q, state_d;
  logic                  ld_q, binm_q, hex_in_q, blz_in_q;
  logic [W-1:0]          val_q;
  logic [NUM_DIGITS-1:0] dpi_q;
  logic                  pend_hex_q, pend_blz_q;
  logic [NUM_DIGITS-1:0] pend_dp_q;
  logic [W-1:0]          disp_q;
  logic                  hex_q, blz_q, done_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [0:6]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic                  start, wr_bcd, wr_bin, conv_valid, tc;
  logic [W-1:0]          conv_bcd, upper;
  bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin(val_q[BIN_W-1:0]),
    .bcd(conv_bcd),
    .valid(conv_valid)
  );
  // register a host load only while the controller is idle; later loads are dropped
  always_ff @(posedge clk)
    if (rst) begin
      ld_q <= 1'b0;
      val_q <= '0;
      binm_q <= 1'b0;
      hex_in_q <= 1'b0;
      blz_in_q <= 1'b0;
      dpi_q <= '0;
    end else begin
      ld_q <= bus.load && state_q == IDLE;
      if (bus.load && state_q == IDLE) begin
        val_q <= bus.value;
        binm_q <= bus.bin_mode;
        hex_in_q <= bus.hex_en;
        blz_in_q <= bus.blank_lz;
        dpi_q <= bus.dp_in;
      end
    end
  // controller next state: BCD commits directly, binary detours through the converter
  always_comb begin
    start = state_q == IDLE && ld_q && binm_q;
    wr_bcd = state_q == IDLE && ld_q && !binm_q;
    wr_bin = state_q == COMMIT;
    state_d = start ? CONV : (state_q == CONV && conv_valid) ? COMMIT : wr_bin ? IDLE : state_q;
  end
  // controller state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // hold display flags of a binary load until its result commits
  always_ff @(posedge clk)
    if (rst) begin
      pend_hex_q <= 1'b0;
      pend_blz_q <= 1'b0;
      pend_dp_q <= '0;
    end else if (start) begin
      pend_hex_q <= hex_in_q;
      pend_blz_q <= blz_in_q;
      pend_dp_q <= dpi_q;
    end
  // display buffer and its update pulse
  always_ff @(posedge clk)
    if (rst) begin
      disp_q <= '0;
      hex_q <= 1'b0;
      blz_q <= 1'b0;
      dp_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= wr_bcd || wr_bin;
      if (wr_bcd) begin
        disp_q <= val_q;
        hex_q <= hex_in_q;
        blz_q <= blz_in_q;
        dp_q <= dpi_q;
      end else if (wr_bin) begin
        disp_q <= conv_bcd;
        hex_q <= pend_hex_q;
        blz_q <= pend_blz_q;
        dp_q <= pend_dp_q;
      end
    end
  assign tc = presc_q == PW'(SCAN_DIV - 1);
  // prescaler and digit index rotation
  always_ff @(posedge clk)
    if (rst) begin
      presc_q <= '0;
      idx_q <= '0;
    end else begin
      presc_q <= tc ? '0 : presc_q + 1'b1;
      if (tc) idx_q <= idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    end
  // decode the selected digit; it is a leading zero when it and all digits above are zero
  always_comb begin
    upper = disp_q >> (4 * idx_q);
    seg_d = (blz_q && idx_q != '0 && upper == '0) ? BLANK : nib2seg(upper[3:0], hex_q);
    an_d = ~(NUM_DIGITS'(1) << idx_q);
    dpo_d = ~dp_q[idx_q];
  end
  // anodes, segments and dp share one register stage so they always switch together
  always_ff @(posedge clk)
    if (rst) begin
      an_q <= '1;
      seg_q <= BLANK;
      dpo_q <= 1'b1;
    end else begin
      an_q <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.seg_out = seg_q;
  assign bus.dp_out = dpo_q;
  assign bus.an_out = an_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: model-checked directed test of the scan driver
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BW = 13;
  localparam logic [0:6] BL = 7'b1111111;
  localparam logic [0:6] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();
  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BIN_W(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  logic [3:0] mbuf [ND];
  logic       mhex, mblz;
  logic [3:0] mdp;
  bit         p_v;
  int         p_at, b_lo, b_hi, e, d, v;
  logic [3:0] p_d [ND];
  logic       p_hex, p_blz;
  logic [3:0] p_dp;
  logic [3:0] e_an;
  logic [0:6] e_seg;
  logic       e_dp, e_busy, e_done, was_busy;
  bit         live = 0;
  function automatic logic [0:6] exp_glyph(input int k);
    int hi;
    hi = 0;
    for (int i = 0; i < ND; i++) if (mbuf[i] != 4'd0) hi = i;
    if (mblz && k > hi) return BL;
    if (mbuf[k] > 4'd9 && !mhex) return BL;
    return TBL[mbuf[k]];
  endfunction
  always @(posedge clk) begin
    live = 1;
    if (rst) begin
      e = 0;
      for (int i = 0; i < ND; i++) mbuf[i] = 4'd0;
      mhex = 0; mblz = 0; mdp = 4'd0; p_v = 0; b_lo = 1; b_hi = 0;
      e_an = 4'hF; e_seg = BL; e_dp = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      was_busy = e_busy;
      e++;
      d = ((e - 1) / SD) % ND;
      e_an = ~(4'b0001 << d);
      e_seg = exp_glyph(d);
      e_dp = ~mdp[d];
      e_done = p_v && p_at == e;
      if (e_done) begin
        mbuf = p_d; mhex = p_hex; mblz = p_blz; mdp = p_dp; p_v = 0;
      end
      e_busy = e >= b_lo && e <= b_hi;
      if (bus.load && !was_busy) begin
        p_v = 1; p_hex = bus.hex_en; p_blz = bus.blank_lz; p_dp = bus.dp_in;
        if (bus.bin_mode) begin
          v = int'(bus.value[BW-1:0]);
          for (int i = 0; i < ND; i++) p_d[i] = 4'((v / (10 ** i)) % 10);
          p_at = e + BW + 2; b_lo = e + 1; b_hi = e + BW + 1;
        end else begin
          for (int i = 0; i < ND; i++) p_d[i] = bus.value[4*i +: 4];
          p_at = e + 1;
        end
      end
    end
  end
  always @(negedge clk) if (live) begin
    chk("an_out", 32'(bus.an_out), 32'(e_an));
    chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
    chk("dp_out", 32'(bus.dp_out), 32'(e_dp));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("done", 32'(bus.done), 32'(e_done));
  end
  logic [0:6] fs [ND];
  logic       fdp [ND];
  task automatic frame();
    for (int i = 0; i < ND; i++) begin fs[i] = 'x; fdp[i] = 'x; end
    repeat (ND * SD) begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) if (bus.an_out[i] == 1'b0) begin
        fs[i] = bus.seg_out;
        fdp[i] = bus.dp_out;
      end
    end
  endtask
  task automatic do_load(input logic [15:0] val, input logic bm, input logic hx,
                         input logic bz, input logic [3:0] dp);
    bus.value = val; bus.bin_mode = bm; bus.hex_en = hx; bus.blank_lz = bz;
    bus.dp_in = dp; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  int bc, dj, nd;
  initial begin
    bus.load = 0; bus.value = '0; bus.bin_mode = 0; bus.hex_en = 0;
    bus.blank_lz = 0; bus.dp_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an_out), 32'hF);
    chk("rst_seg", 32'(bus.seg_out), 32'(7'b1111111));
    chk("rst_dp", 32'(bus.dp_out), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("first_an", 32'(bus.an_out), 32'(4'b1110));
    chk("first_seg", 32'(bus.seg_out), 32'(7'b0000001));
    repeat (4) @(negedge clk);
    chk("rotate_an", 32'(bus.an_out), 32'(4'b1101));
    do_load(16'h1234, 0, 0, 0, 4'b0000);
    chk("bcd_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("bcd_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    frame();
    chk("bcd_d0", 32'(fs[0]), 32'(7'b1001100));
    chk("bcd_d1", 32'(fs[1]), 32'(7'b0000110));
    chk("bcd_d2", 32'(fs[2]), 32'(7'b0010010));
    chk("bcd_d3", 32'(fs[3]), 32'(7'b1001111));
    do_load(16'd1234, 1, 0, 0, 4'b0000);
    bc = 0; dj = 0;
    for (int j = 1; j <= 40 && dj == 0; j++) begin
      if (j == 3) begin
        bus.load = 1; bus.bin_mode = 0; bus.value = 16'h5678;
      end else bus.load = 0;
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) dj = j;
    end
    bus.load = 0;
    chk("bin_busy_cycles", 32'(bc), 32'd14);
    chk("bin_done_latency", 32'(dj), 32'd15);
    @(negedge clk);
    frame();
    chk("bin_d0", 32'(fs[0]), 32'(7'b1001100));
    chk("bin_d1", 32'(fs[1]), 32'(7'b0000110));
    chk("bin_d2", 32'(fs[2]), 32'(7'b0010010));
    chk("bin_d3", 32'(fs[3]), 32'(7'b1001111));
    do_load(16'h00AF, 0, 1, 1, 4'b0000);
    repeat (2) @(negedge clk);
    frame();
    chk("hex_d3", 32'(fs[3]), 32'(7'b1111111));
    chk("hex_d2", 32'(fs[2]), 32'(7'b1111111));
    chk("hex_d1", 32'(fs[1]), 32'(7'b0001000));
    chk("hex_d0", 32'(fs[0]), 32'(7'b0111000));
    do_load(16'h00AF, 0, 0, 1, 4'b0000);
    repeat (2) @(negedge clk);
    frame();
    chk("nohex_d1", 32'(fs[1]), 32'(7'b1111111));
    chk("nohex_d0", 32'(fs[0]), 32'(7'b1111111));
    do_load(16'd1234, 1, 0, 0, 4'b0000);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk("abort_quiet", 32'(nd), 32'd0);
    frame();
    chk("abort_d3", 32'(fs[3]), 32'(7'b0000001));
    chk("abort_d0", 32'(fs[0]), 32'(7'b0000001));
    do_load(16'h0000, 0, 0, 1, 4'b0010);
    repeat (2) @(negedge clk);
    frame();
    chk("dp_d1_seg", 32'(fs[1]), 32'(7'b1111111));
    chk("dp_d1_dp", 32'(fdp[1]), 32'd0);
    chk("dp_d0_seg", 32'(fs[0]), 32'(7'b0000001));
    chk("dp_d0_dp", 32'(fdp[0]), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
